// File: rtl/comp_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : comp_result_checker
//  Brief    : Receive-side checker for the 2-bit comparator cell. It recomputes
//             eq/lt/gt for each accepted sample, counts checked and failing
//             vectors, and reports pass/fail once a full sweep has been seen.
//             Optional macro FIRST_FAIL_CAPTURE_EN adds first-failure capture
//             ports (ff_valid, ff_a, ff_b, ff_flags).
//  Revision : 1.0 - initial release
// ============================================================================
module comp_result_checker #(
    parameter int WIDTH       = 2,
    parameter int NUM_VECTORS = 16,
    localparam int CNT_W      = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_eq,
    input  logic             in_lt,
    input  logic             in_gt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic             ff_valid,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic [2:0]       ff_flags
`endif
);

    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    logic [2:0]       w_flags_exp;
    logic [2:0]       w_flags_obs;
    logic             w_sample_bad;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_last;
    logic [CNT_W-1:0] w_fail_next;

    // Unsigned relation; exactly one expected flag is ever set, so any
    // non-one-hot observation automatically mismatches.
    assign w_flags_exp  = {(in_a == in_b), (in_a < in_b), (in_a > in_b)};
    assign w_flags_obs  = {in_eq, in_lt, in_gt};
    assign w_sample_bad = (w_flags_obs != w_flags_exp);

    assign w_accept   = (r_state == S_RUN) && in_valid;
    assign w_start_ok = (r_state != S_RUN) && start;
    assign w_last     = (r_vec_cnt == c_LAST);

    always_comb begin
        w_fail_next = r_fail_cnt;
        if (w_sample_bad && (r_fail_cnt != c_CNT_MAX)) begin
            w_fail_next = r_fail_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_mismatch <= 1'b0;
            r_vec_cnt  <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_mismatch <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_vec_cnt  <= '0;
                        r_fail_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_vec_cnt  <= r_vec_cnt + 1'b1;
                        r_fail_cnt <= w_fail_next;
                        r_mismatch <= w_sample_bad;
                        // pass uses the post-update count so the final sample counts
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_fail_next == '0);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign mismatch = r_mismatch;
    assign vec_cnt  = r_vec_cnt;
    assign fail_cnt = r_fail_cnt;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic             r_ff_valid;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic [2:0]       r_ff_flags;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_ff_valid <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_flags <= '0;
        end else if (w_accept && w_sample_bad && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_a     <= in_a;
            r_ff_b     <= in_b;
            r_ff_flags <= w_flags_obs;
        end
    end

    assign ff_valid = r_ff_valid;
    assign ff_a     = r_ff_a;
    assign ff_b     = r_ff_b;
    assign ff_flags = r_ff_flags;
`else
    logic w_unused;
    assign w_unused = w_start_ok;
`endif

endmodule
`default_nettype wire
